// File: rtl/lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one update datapath.
// Optional per-channel saturating spike counters are enabled with `define LIF_SPIKE_COUNT_EN.
module lif_array #(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned REFRAC_W = 4,
   localparam int unsigned IdxW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  step,
   input  logic [N_CH*WIDTH-1:0] cur_in,
   input  logic [WIDTH-1:0]      threshold,
   input  logic [2:0]            leak_shift,
   input  logic [REFRAC_W-1:0]   refrac,
   input  logic [IdxW-1:0]       sel,
   output logic [N_CH-1:0]       spike_out,
   output logic                  spike_valid,
   output logic                  busy,
   output logic [WIDTH-1:0]      state_out,
   output logic [7:0]            count_out
);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(N_CH - 1);

   typedef enum logic [0:0] {StIdle, StRun} fsm_e;

   fsm_e fsm_q, fsm_d;

   logic [IdxW-1:0]       idx_q;
   logic [N_CH*WIDTH-1:0] cur_q;
   logic [WIDTH-1:0]      thr_q;
   logic [2:0]            leak_q;
   logic [REFRAC_W-1:0]   refrac_q;

   logic [WIDTH-1:0]      mem_q [N_CH];
   logic [REFRAC_W-1:0]   ref_q [N_CH];
   logic [N_CH-1:0]       shadow_q, shadow_d;
   logic [N_CH-1:0]       spike_out_q;
   logic                  spike_valid_q;

   logic accept, upd, last;

   logic [WIDTH-1:0]    s_cur, s_mem, leaked, sat, mem_nx;
   logic [REFRAC_W-1:0] s_ref, ref_nx;
   logic [WIDTH:0]      sum;
   logic                fire;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q <= StIdle;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      unique case (fsm_q)
         StIdle: if (ena && step) fsm_d = StRun;
         StRun:  if (ena && (idx_q == LastIdx)) fsm_d = StIdle;
         default: fsm_d = StIdle;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      upd    = 1'b0;
      last   = 1'b0;
      busy   = 1'b0;
      unique case (fsm_q)
         StIdle: accept = ena & step;
         StRun: begin
            busy = 1'b1;
            upd  = ena;
            last = ena & (idx_q == LastIdx);
         end
         default: ;
      endcase
   end

   // ---------------- Snapshot and channel index ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         cur_q    <= '0;
         thr_q    <= '0;
         leak_q   <= '0;
         refrac_q <= '0;
      end else if (accept) begin
         idx_q    <= '0;
         cur_q    <= cur_in;
         thr_q    <= threshold;
         leak_q   <= leak_shift;
         refrac_q <= refrac;
      end else if (upd) begin
         idx_q <= last ? '0 : idx_q + IdxW'(1);
      end
   end

   // ---------------- Shared update datapath ----------------
   always_comb begin
      s_cur = '0;
      s_mem = '0;
      s_ref = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (idx_q == IdxW'(i)) begin
            s_cur = cur_q[i*WIDTH +: WIDTH];
            s_mem = mem_q[i];
            s_ref = ref_q[i];
         end
      end
   end

   always_comb begin
      // A zero shift means no leak, not "subtract the whole state".
      leaked = (leak_q == 3'd0) ? s_mem : s_mem - (s_mem >> leak_q);
      sum    = {1'b0, leaked} + {1'b0, s_cur};
      sat    = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      fire   = 1'b0;
      mem_nx = '0;
      ref_nx = '0;
      if (s_ref != '0) begin
         ref_nx = s_ref - REFRAC_W'(1);
      end else if (sat >= thr_q) begin
         fire   = 1'b1;
         ref_nx = refrac_q;
      end else begin
         mem_nx = sat;
      end
   end

   always_comb begin
      shadow_d = shadow_q;
      for (int i = 0; i < N_CH; i++) begin
         if (idx_q == IdxW'(i)) shadow_d[i] = fire;
      end
   end

   // ---------------- Per-channel state ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            mem_q[i] <= '0;
            ref_q[i] <= '0;
         end
      end else if (upd) begin
         for (int i = 0; i < N_CH; i++) begin
            if (idx_q == IdxW'(i)) begin
               mem_q[i] <= mem_nx;
               ref_q[i] <= ref_nx;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q    <= '0;
         spike_out_q <= '0;
      end else if (upd) begin
         shadow_q <= shadow_d;
         if (last) spike_out_q <= shadow_d;
      end
   end

   // Pulse register tracks the last update every cycle so it can never stick high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike_valid_q <= 1'b0;
      end else begin
         spike_valid_q <= last;
      end
   end

   assign spike_out   = spike_out_q;
   assign spike_valid = spike_valid_q & ena;

   always_comb begin
      state_out = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel == IdxW'(i)) state_out = mem_q[i];
      end
   end

   // ---------------- Optional spike counters ----------------
`ifdef LIF_SPIKE_COUNT_EN
   logic [7:0] cnt_q [N_CH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else if (upd && fire) begin
         for (int i = 0; i < N_CH; i++) begin
            if ((idx_q == IdxW'(i)) && (cnt_q[i] != 8'hFF)) cnt_q[i] <= cnt_q[i] + 8'd1;
         end
      end
   end

   always_comb begin
      count_out = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel == IdxW'(i)) count_out = cnt_q[i];
      end
   end
`else
   assign count_out = '0;
`endif

endmodule

// File: tb/tb_lif_array.sv
// Randomized self-checking bench for lif_array against a timestep-level reference model.
module tb_lif_array;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int RW = 4;
   localparam int SW = $clog2(N);

   logic           clk = 1'b0;
   logic           rst_n, ena, step;
   logic [N*W-1:0] cur_in;
   logic [W-1:0]   threshold;
   logic [2:0]     leak_shift;
   logic [RW-1:0]  refrac;
   logic [SW-1:0]  sel;
   logic [N-1:0]   spike_out;
   logic           spike_valid, busy;
   logic [W-1:0]   state_out;
   logic [7:0]     count_out;

   lif_array #(.N_CH(N), .WIDTH(W), .REFRAC_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .step(step), .cur_in(cur_in),
      .threshold(threshold), .leak_shift(leak_shift), .refrac(refrac), .sel(sel),
      .spike_out(spike_out), .spike_valid(spike_valid), .busy(busy),
      .state_out(state_out), .count_out(count_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: membrane, refractory and spike count per neuron.
   int ms [N];
   int mr [N];
   int mc [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         ms[i] = 0;
         mr[i] = 0;
         mc[i] = 0;
      end
   endtask

   task automatic model_step(input logic [N*W-1:0] cur, input int thr, input int ls, input int rf,
                             output logic [N-1:0] spk);
      int lk, sum;
      spk = '0;
      for (int i = 0; i < N; i++) begin
         if (mr[i] != 0) begin
            ms[i] = 0;
            mr[i] = mr[i] - 1;
         end else begin
            lk  = (ls == 0) ? ms[i] : ms[i] - (ms[i] >> ls);
            sum = lk + int'(cur[i*W +: W]);
            if (sum > (1 << W) - 1) sum = (1 << W) - 1;
            if (sum >= thr) begin
               spk[i] = 1'b1;
               ms[i]  = 0;
               mr[i]  = rf;
               if (mc[i] < 255) mc[i] = mc[i] + 1;
            end else begin
               ms[i] = sum;
            end
         end
      end
   endtask

   function automatic int exp_count(input int i);
`ifdef LIF_SPIKE_COUNT_EN
      return mc[i];
`else
      return (i < 0) ? 1 : 0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         sel = SW'(i);
         #1;
         check("state", 32'(state_out), ms[i]);
         check("count", 32'(count_out), exp_count(i));
      end
   endtask

   function automatic logic [N*W-1:0] fill(input int v);
      logic [N*W-1:0] c;
      for (int i = 0; i < N; i++) c[i*W +: W] = W'(v);
      return c;
   endfunction

   function automatic logic [N*W-1:0] rand_cur();
      logic [N*W-1:0] c;
      for (int i = 0; i < N; i++) c[i*W +: W] = W'($urandom);
      return c;
   endfunction

   task automatic drive(input logic [N*W-1:0] cur, input int thr, input int ls, input int rf);
      cur_in     = cur;
      threshold  = W'(thr);
      leak_shift = 3'(ls);
      refrac     = RW'(rf);
   endtask

   // One full timestep with cycle-exact checks of busy, per-channel timing and the valid pulse.
   task automatic do_step(input logic [N*W-1:0] cur, input int thr, input int ls, input int rf);
      logic [N-1:0] spk;
      model_step(cur, thr, ls, rf, spk);
      drive(cur, thr, ls, rf);
      step = 1'b1;
      tick();
      step = 1'b0;
      // Scramble live inputs: the sweep must use the snapshot.
      drive(rand_cur(), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 15)));
      check("busy_start", 32'(busy), 1);
      for (int n = 0; n < N; n++) begin
         sel = SW'(n);
         tick();
         check("state_timing", 32'(state_out), ms[n]);
         if (n < N - 1) check("valid_early", 32'(spike_valid), 0);
      end
      check("spike_valid", 32'(spike_valid), 1);
      check("busy_end", 32'(busy), 0);
      check("spike_out", 32'(spike_out), 32'(spk));
      tick();
      check("valid_pulse", 32'(spike_valid), 0);
      check_all();
   endtask

   int leak_exp [8] = '{40, 60, 70, 75, 78, 79, 80, 80};
   int sat_exp  [5] = '{200, 0, 0, 0, 200};
   int sat_spk  [5] = '{0, 1, 0, 0, 0};

   initial begin
      logic [N-1:0]   spk;
      logic [N*W-1:0] c;
      int             nv, nb, g;

      rst_n = 1'b0;
      ena   = 1'b1;
      step  = 1'b0;
      sel   = '0;
      drive('0, 0, 0, 0);
      model_reset();

      // Reset holds everything at zero despite toggling inputs.
      repeat (3) begin
         drive(rand_cur(), int'($urandom_range(0, 255)), 0, 1);
         step = 1'($urandom);
         sel  = SW'($urandom);
         tick();
         check("rst_spike_out", 32'(spike_out), 0);
         check("rst_valid", 32'(spike_valid), 0);
         check("rst_busy", 32'(busy), 0);
         check("rst_state", 32'(state_out), 0);
         check("rst_count", 32'(count_out), 0);
      end
      step = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check_all();

      // Integrate and fire on channel 0.
      c = '0;
      c[W-1:0] = W'(50);
      do_step(c, 100, 0, 0);
      sel = '0;
      #1;
      check("int_state1", 32'(state_out), 50);
      check("int_nospike", 32'(spike_out[0]), 0);
      do_step(c, 100, 0, 0);
      sel = '0;
      #1;
      check("int_spike", 32'(spike_out[0]), 1);
      check("int_state2", 32'(state_out), 0);

      // Leak converges without firing.
      for (int s = 0; s < 8; s++) begin
         do_step(fill(40), 255, 1, 0);
         sel = '0;
         #1;
         check("leak_state", 32'(state_out), leak_exp[s]);
         check("leak_nospike", 32'(spike_out), 0);
      end

      // Saturation then refractory, from a clean reset.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      tick();
      for (int s = 0; s < 5; s++) begin
         do_step(fill(200), 255, 0, 2);
         sel = '0;
         #1;
         check("sat_state", 32'(state_out), sat_exp[s]);
         check("sat_spike", 32'(spike_out[0]), sat_spk[s]);
      end
      sel = '0;
      #1;
`ifdef LIF_SPIKE_COUNT_EN
      check("sat_count", 32'(count_out), 1);
`else
      check("sat_count", 32'(count_out), 0);
`endif

      // Step pulsed during a sweep is dropped.
      c = rand_cur();
      model_step(c, 150, 2, 1, spk);
      drive(c, 150, 2, 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      nv = 0;
      repeat (2 * N + 4) begin
         tick();
         nv += int'(spike_valid);
      end
      check("ignored_step_valids", nv, 1);
      check("ignored_step_spikes", 32'(spike_out), 32'(spk));
      check_all();

      // Pausing with ena stretches the sweep by the pause length.
      c = rand_cur();
      model_step(c, 120, 1, 1, spk);
      drive(c, 120, 1, 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      nb = int'(busy);
      tick();
      nb += int'(busy);
      ena = 1'b0;
      repeat (3) begin
         tick();
         nb += int'(busy);
         check("pause_valid", 32'(spike_valid), 0);
      end
      ena = 1'b1;
      g = 0;
      while (busy && g < 20) begin
         tick();
         nb += int'(busy);
         g++;
      end
      check("pause_busy_len", nb, N + 3);
      check("pause_valid_end", 32'(spike_valid), 1);
      check("pause_spikes", 32'(spike_out), 32'(spk));
      tick();
      check_all();

      // Reset at the third edge of a sweep discards it.
      drive(fill(200), 10, 0, 0);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midrst_busy", 32'(busy), 0);
      check("midrst_spike_out", 32'(spike_out), 0);
      check("midrst_valid", 32'(spike_valid), 0);
      check_all();
      tick();
      rst_n = 1'b1;
      nv = 0;
      repeat (N + 4) begin
         tick();
         nv += int'(spike_valid);
      end
      check("midrst_no_valid", nv, 0);
      c = '0;
      c[W-1:0] = W'(50);
      do_step(c, 100, 0, 0);

      // Randomized timesteps, including zero thresholds.
      repeat (40) begin
         do_step(rand_cur(), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/lif_array.md
# lif_array

Time-multiplexed array of `N_CH` leaky integrate-and-fire neurons sharing one update datapath; successor to the single-neuron `tt_um_lif` core, generalised in channel count and membrane width. Adds leak, saturating integration and a refractory period. Each `step` pulse advances every neuron by one timestep, sweeping channels at one per clock. Sits behind the TinyTapeout top-level wrapper, which drives its configuration and currents from `ui_in`/`uio_in` registers.

## Interface
- `N_CH`, 4, number of neurons (≥2)
- `WIDTH`, 8, membrane/current/threshold width in bits
- `REFRAC_W`, 4, refractory counter width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `ena` in 1: high = FSM advances; low = FSM and all state hold
- `step` in 1: request one timestep; sampled only in IDLE with `ena`=1
- `cur_in` in `N_CH*WIDTH`: unsigned input currents, channel i at bits [i*WIDTH +: WIDTH]
- `threshold` in `WIDTH`: firing threshold (unsigned)
- `leak_shift` in 3: leak = state>>leak_shift; 0 = no leak
- `refrac` in `REFRAC_W`: refractory steps after a spike
- `sel` in clog2(`N_CH`): channel observed on `state_out`/`count_out`
- `spike_out` out `N_CH`: spikes of last completed timestep
- `spike_valid` out 1: one-cycle pulse when `spike_out` updates
- `busy` out 1: sweep in progress
- `state_out` out `WIDTH`: membrane of channel `sel` (combinational mux of registers)
- `count_out` out 8: spike count of channel `sel` (see Configuration)

## Operation
- FSM: IDLE → RUN (idx 0..N_CH-1) → IDLE.
- IDLE, `ena`=1, `step`=1: snapshot `cur_in`, `threshold`, `leak_shift`, `refrac`; idx←0; enter RUN.
- RUN: each enabled cycle updates channel idx from the snapshot; idx increments; after idx=N_CH-1 return to IDLE.
- Per-channel update (r = refractory counter, s = state):
  - r≠0: s←0, r←r-1, no spike, current ignored.
  - else leaked = (leak_shift=0) ? s : s-(s>>leak_shift); sum = leaked+cur computed in WIDTH+1 bits, saturated to 2^WIDTH-1.
  - sum ≥ threshold: spike, s←0, r←refrac.
  - else s←sum, no spike.
- Spikes collected in a shadow vector; copied to `spike_out` on the last channel's update edge.
- `step` in RUN: ignored (not queued).
- `ena`=0: FSM, idx, states, counters frozen; `spike_valid` forced 0; resumes where left when `ena` returns.
- `threshold`=0: every non-refractory channel spikes each step.

## Timing
- Reset values: all states, refractory counters, spike counters, `spike_out`, `spike_valid`, `busy` = 0; FSM IDLE.
- `step` sampled at edge k → `busy`=1 after edge k; channel i updated at edge k+1+i; `spike_out` updated and `busy`=0 after edge k+N_CH; `spike_valid`=1 for the cycle following edge k+N_CH only (with continuous `ena`).
- Earliest next accepted `step`: edge k+N_CH+1 → one timestep per N_CH+1 cycles.
- `state_out` reflects channel i from edge k+1+i.
- Reset asserted mid-sweep: immediate clear of everything; partial sweep discarded; no `spike_valid`.

## Configuration
- `LIF_SPIKE_COUNT_EN` defined: per-channel 8-bit spike counter, +1 per spike, saturating at 255, cleared only by reset; `count_out` = counter of `sel`.
- Undefined: no counter registers; `count_out` tied to 0.

## Test plan
- Reset: hold `rst_n`=0, toggle inputs → all outputs 0; release, `state_out`=0 for every `sel`.
- Integrate/fire, N_CH=4, threshold=100, leak_shift=0, ch0 cur=50: step 1 → state 50, no spike; step 2 → spike_out[0]=1, state 0; `spike_valid` exactly 5 cycles after `step`.
- Leak: leak_shift=1, cur=40, threshold=255: states 40,60,70,75,78,79,80,80 over 8 steps; no spike.
- Saturation + refractory: cur=200, threshold=255, refrac=2: step 1 → 200; step 2 → sum saturates to 255, spike; steps 3–4 → state 0, no spike; step 5 → 200; count_out=1 with `LIF_SPIKE_COUNT_EN`.
- Busy rules: `step` pulsed during RUN ignored (one `spike_valid` only); `ena`=0 for 3 cycles mid-sweep extends `busy` by exactly 3 cycles.
- Reset mid-sweep at edge k+2: all state 0, `spike_valid` never asserts, next `step` behaves as first step after reset.
